// File: rtl/serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sequencer
// Purpose  : Bit-serial adder controller. A single full-adder slice is walked
//            LSB-first across WIDTH clock cycles. Operands are captured into
//            shift registers on an accepted start, the running carry lives
//            in a flop between bits, and the result is reported through a
//            start/busy/done handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH      operand/result width in bits (>= 2)
//   CNT_W      bit-counter width, derived from WIDTH (do not override)
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request a new operation (honoured in IDLE or DONE only)
//   op_a/op_b  operands, captured when start is accepted
//   cin        initial carry-in, captured when start is accepted
//   sub        (SERIAL_ADD_SUB_EN only) subtract A-B, captured with start
//   busy       high while the serial add is running
//   done       one-cycle pulse, result valid
//   sum        result, held until the next result is produced
//   carry_out  carry out of the MSB (for subtract: 1 = no borrow)
//   overflow   signed overflow (carry into MSB xor carry out of MSB)
// Build option:
//   SERIAL_ADD_SUB_EN  adds the sub port and the A-B path
// ============================================================================
module serial_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_accept;
  logic               w_last;

  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_res_sr;
  logic               r_c_q;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry_out;
  logic               r_overflow;

  logic [WIDTH-1:0]   w_b_in;
  logic               w_c_in;

  logic               w_p;
  logic               w_g;
  logic               w_s;
  logic               w_cout;

  // Operand conditioning at capture time
`ifdef SERIAL_ADD_SUB_EN
  // A - B == A + ~B + 1; the caller's cin is ignored when subtracting
  assign w_b_in = sub ? ~op_b : op_b;
  assign w_c_in = sub ? 1'b1  : cin;
`else
  assign w_b_in = op_b;
  assign w_c_in = cin;
`endif

  // Full-adder slice in generate/propagate form
  assign w_p    = r_a_sr[0] ^ r_b_sr[0];
  assign w_g    = r_a_sr[0] & r_b_sr[0];
  assign w_s    = w_p ^ r_c_q;
  assign w_cout = w_g | (w_p & r_c_q);

  // The counter holds the index of the bit being processed on this edge
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, handshake and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_res_sr    <= '0;
      r_c_q       <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Registered decode of the state being entered, so busy and done
      // can never overlap
      r_busy  <= (w_next_state == S_RUN);
      r_done  <= (r_state == S_RUN) && w_last;

      if (w_accept) begin
        r_a_sr   <= op_a;
        r_b_sr   <= w_b_in;
        r_c_q    <= w_c_in;
        r_res_sr <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_RUN) begin
        r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
        r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
        r_res_sr <= {w_s, r_res_sr[WIDTH-1:1]};
        r_c_q    <= w_cout;
        if (w_last) begin
          // On the MSB edge r_c_q is the carry into the MSB, so the signed
          // overflow is simply carry-in(MSB) xor carry-out(MSB).
          r_sum       <= {w_s, r_res_sr[WIDTH-1:1]};
          r_carry_out <= w_cout;
          r_overflow  <= r_c_q ^ w_cout;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sequencer
// Purpose  : Self-checking bench for serial_add_sequencer at WIDTH=8.
//            Directed scenarios plus randomized operations compared against
//            an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sequencer;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a  = '0;
  logic [W-1:0] op_b  = '0;
  logic         cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub   = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int n_pass   = 0;
  int n_checks = 0;

  serial_add_sequencer #(.WIDTH(W)) dut (
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic. Returns {overflow, carry_out, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
    int           bi, ci, tot, sa, sb, sres;
    logic [W-1:0] r;
    logic         co, ov;
    if (s) begin
      bi = (2 ** W - 1) - int'(b);
      ci = 1;
    end else begin
      bi = int'(b);
      ci = int'(c);
    end
    tot  = int'(a) + bi + ci;
    r    = W'(tot % (2 ** W));
    co   = (tot >= 2 ** W);
    sa   = (int'(a) >= 2 ** (W - 1)) ? int'(a) - 2 ** W : int'(a);
    sb   = (bi >= 2 ** (W - 1)) ? bi - 2 ** W : bi;
    sres = sa + sb + ci;
    ov   = (sres > 2 ** (W - 1) - 1) || (sres < -(2 ** (W - 1)));
    return {ov, co, r};
  endfunction

  // Drive a start for one edge, then scramble the operand inputs.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = W'($urandom);
    op_b  = W'($urandom);
    cin   = 1'($urandom);
  endtask

  // Wait (bounded) for done; cyc counts edges after the accepting edge.
  // inject_at >= 0 raises start with junk operands for one cycle mid-run.
  task automatic wait_done(input int inject_at, output int cyc, output int busy_n);
    cyc    = 0;
    busy_n = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_n++;
      if (cyc == inject_at) begin
        start = 1'b1;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (sum !== 8'h00) $display("FAIL reset_sum: got %h want 00", sum); else n_pass++;
    n_checks++; if (carry_out !== 1'b0) $display("FAIL reset_cout: got %b want 0", carry_out); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc, bn;
    launch(8'h0F, 8'h01, 1'b0);
    wait_done(-1, cyc, bn);
    n_checks++; if (cyc !== 8) $display("FAIL basic_latency: got %0d want 8", cyc); else n_pass++;
    n_checks++; if (bn !== 8) $display("FAIL basic_busy_cycles: got %0d want 8", bn); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", busy); else n_pass++;
    n_checks++; if (sum !== 8'h10) $display("FAIL basic_sum: got %h want 10", sum); else n_pass++;
    n_checks++; if (carry_out !== 1'b0) $display("FAIL basic_cout: got %b want 0", carry_out); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL basic_ovf: got %b want 0", overflow); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else n_pass++;
    n_checks++; if (sum !== 8'h10) $display("FAIL basic_sum_hold: got %h want 10", sum); else n_pass++;
  endtask

  task automatic test_carry();
    int cyc, bn;
    launch(8'hFF, 8'h01, 1'b0);
    wait_done(-1, cyc, bn);
    n_checks++; if (sum !== 8'h00) $display("FAIL carry_sum: got %h want 00", sum); else n_pass++;
    n_checks++; if (carry_out !== 1'b1) $display("FAIL carry_cout: got %b want 1", carry_out); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL carry_ovf: got %b want 0", overflow); else n_pass++;
    @(posedge clk); #1;
    launch(8'h7F, 8'h01, 1'b0);
    wait_done(-1, cyc, bn);
    n_checks++; if (sum !== 8'h80) $display("FAIL ovf_sum: got %h want 80", sum); else n_pass++;
    n_checks++; if (carry_out !== 1'b0) $display("FAIL ovf_cout: got %b want 0", carry_out); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_ovf: got %b want 1", overflow); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc, bn;
    launch(8'h10, 8'h20, 1'b1);
    wait_done(-1, cyc, bn);
    n_checks++; if (sum !== 8'h31) $display("FAIL b2b_first_sum: got %h want 31", sum); else n_pass++;
    // Still in the DONE cycle: start again immediately
    launch(8'h80, 8'h80, 1'b0);
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy_restart: got %b want 1", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL b2b_done_low: got %b want 0", done); else n_pass++;
    wait_done(-1, cyc, bn);
    // cyc counts from the accepting edge, one edge after the first done
    n_checks++; if (cyc + 1 !== 9) $display("FAIL b2b_spacing: got %0d want 9", cyc + 1); else n_pass++;
    n_checks++; if (sum !== 8'h00) $display("FAIL b2b_sum: got %h want 00", sum); else n_pass++;
    n_checks++; if (carry_out !== 1'b1) $display("FAIL b2b_cout: got %b want 1", carry_out); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL b2b_ovf: got %b want 1", overflow); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_start_during_run();
    int cyc, bn, extra;
    launch(8'h3C, 8'h42, 1'b0);
    wait_done(2, cyc, bn);
    n_checks++; if (cyc !== 8) $display("FAIL run_start_latency: got %0d want 8", cyc); else n_pass++;
    n_checks++; if (sum !== 8'h7E) $display("FAIL run_start_sum: got %h want 7E", sum); else n_pass++;
    n_checks++; if (carry_out !== 1'b0) $display("FAIL run_start_cout: got %b want 0", carry_out); else n_pass++;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++; if (extra !== 0) $display("FAIL run_start_idle: got %0d active cycles want 0", extra); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int cyc, bn, seen;
    launch(8'hAA, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL mreset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (sum !== 8'h00) $display("FAIL mreset_sum: got %h want 00", sum); else n_pass++;
    n_checks++; if ({done, carry_out, overflow} !== 3'b000) $display("FAIL mreset_flags: got %b want 000", {done, carry_out, overflow}); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL mreset_no_done: got %0d pulses want 0", seen); else n_pass++;
    launch(8'h12, 8'h34, 1'b1);
    wait_done(-1, cyc, bn);
    n_checks++; if (cyc !== 8) $display("FAIL mreset_fresh_latency: got %0d want 8", cyc); else n_pass++;
    n_checks++; if (sum !== 8'h47) $display("FAIL mreset_fresh_sum: got %h want 47", sum); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int           cyc, bn;
    logic [W-1:0] a, b;
    logic         c;
    logic [W+1:0] exp;
    for (int i = 0; i < 30; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      c   = 1'($urandom);
      exp = model(a, b, c, 1'b0);
      launch(a, b, c);
      wait_done(-1, cyc, bn);
      n_checks++; if (cyc !== 8) $display("FAIL rand_latency[%0d]: got %0d want 8", i, cyc); else n_pass++;
      n_checks++;
      if ({overflow, carry_out, sum} !== exp)
        $display("FAIL rand_result[%0d] %h+%h+%b: got ov=%b co=%b s=%h want ov=%b co=%b s=%h",
                 i, a, b, c, overflow, carry_out, sum, exp[W+1], exp[W], exp[W-1:0]);
      else n_pass++;
      // Odd iterations restart straight from DONE; others idle a little
      if (i % 2 == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    @(posedge clk); #1;
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    int           cyc, bn;
    logic [W-1:0] a, b;
    logic [W+1:0] exp;
    sub = 1'b1;
    launch(8'h05, 8'h07, 1'b0);
    wait_done(-1, cyc, bn);
    n_checks++; if (sum !== 8'hFE) $display("FAIL sub_sum1: got %h want FE", sum); else n_pass++;
    n_checks++; if (carry_out !== 1'b0) $display("FAIL sub_cout1: got %b want 0", carry_out); else n_pass++;
    @(posedge clk); #1;
    launch(8'h80, 8'h01, 1'b0);
    wait_done(-1, cyc, bn);
    n_checks++; if (sum !== 8'h7F) $display("FAIL sub_sum2: got %h want 7F", sum); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL sub_ovf2: got %b want 1", overflow); else n_pass++;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      exp = model(a, b, 1'b0, 1'b1);
      launch(a, b, 1'($urandom));
      wait_done(-1, cyc, bn);
      n_checks++;
      if ({overflow, carry_out, sum} !== exp)
        $display("FAIL sub_rand[%0d] %h-%h: got ov=%b co=%b s=%h want ov=%b co=%b s=%h",
                 i, a, b, overflow, carry_out, sum, exp[W+1], exp[W], exp[W-1:0]);
      else n_pass++;
    end
    sub = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_start_during_run();
    test_mid_reset();
    test_random();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
